// File: rtl/upcounter_run_ctrl.sv
// Run/stop/clear controller with a divider-based count strobe and wrapping count register.
// The divider only advances in RUN, so stopping and resuming keeps the tick phase.
module upcounter_run_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int FAST_MULT = 10,
  parameter int COUNT_MAX = 9999,
  parameter int CW        = 14
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_run_stop,
  input  logic          i_clear,
  input  logic          i_fast,
  output logic [CW-1:0] o_count,
  output logic          o_tick,
  output logic          o_wrap,
  output logic          o_running
);

  localparam int DIV_N = CLK_HZ / TICK_HZ;
  localparam int DIV_F = (DIV_N / FAST_MULT) < 1 ? 1 : (DIV_N / FAST_MULT);
  localparam int PW    = (DIV_N > 1) ? $clog2(DIV_N) : 1;

  localparam logic [PW-1:0] LIM_N = PW'(DIV_N - 1);
  localparam logic [PW-1:0] LIM_F = PW'(DIV_F - 1);
  localparam logic [CW-1:0] CMAX  = CW'(COUNT_MAX);

  typedef enum logic {STOP, RUN} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [PW-1:0] lim;
  logic          tick_evt;

  // ">=" lets a mid-period switch to the fast divider fire on the very next RUN cycle.
  always_comb begin
    lim      = i_fast ? LIM_F : LIM_N;
    tick_evt = (state == RUN) && (presc >= lim);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= STOP;
      presc     <= '0;
      o_count   <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_running <= 1'b0;
    end else if (i_clear) begin
      state     <= STOP;
      presc     <= '0;
      o_count   <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_running <= 1'b0;
    end else begin
      if (i_run_stop) begin
        state     <= (state == RUN) ? STOP : RUN;
        o_running <= (state != RUN);
      end
      if (state == RUN)
        presc <= tick_evt ? '0 : presc + PW'(1);
      // A tick landing on the stop pulse still counts.
      o_tick <= tick_evt;
      o_wrap <= tick_evt && (o_count == CMAX);
      if (tick_evt)
        o_count <= (o_count == CMAX) ? '0 : o_count + CW'(1);
    end
  end

endmodule
